// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One spare bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder used as the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles.
// Subtraction is a + ~b + 1; results are registered on the edge entering DONE.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for start; operands captured on start
//   SHIFT | one bit per cycle through fa_cell
//   DONE  | one-cycle result-valid pulse, then IDLE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             fa_s;
  logic             fa_cout;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // a_sh doubles as the sum accumulator: each result bit enters at the MSB
  // as the consumed operand bit leaves at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= sub ? ~b : b;
      carry   <= sub ? 1'b1 : cin;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      a_sh    <= {fa_s, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      carry   <= fa_cout;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // On the MSB cycle, carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_bit) begin
      sum  <= {fa_s, a_sh[WIDTH-1:1]};
      cout <= fa_cout;
      ovf  <= carry ^ fa_cout;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16.
// Expected results come from a plain-arithmetic model; monitors pop on done.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cin_i, sub_i;
  logic        rst8, start8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        rst16, start16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin_i), .sub(sub_i),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin_i), .sub(sub_i),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a + b + cin, or a + ~b + 1, taken mod 2^w with flags from plain arithmetic.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic c, input logic s, input int done_cyc);
    exp_t        e;
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    logic        c0;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa     = av & mask;
    bb     = (s ? ~bv : bv) & mask;
    c0     = s ? 1'b1 : c;
    full   = {1'b0, aa} + {1'b0, bb} + {32'd0, c0};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    e.cyc  = done_cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8_unexpected: actual done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sum8", {24'd0, sum8}, e.sum);
        check("cout8", {31'd0, cout8}, {31'd0, e.cout});
        check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
        check("latency8", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done16_unexpected: actual done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("sum16", {16'd0, sum16}, e.sum);
        check("cout16", {31'd0, cout16}, {31'd0, e.cout});
        check("ovf16", {31'd0, ovf16}, {31'd0, e.ovf});
        check("latency16", cyc, e.cyc);
      end
    end
  end

  task automatic scramble();
    a8    = 8'($urandom);
    b8    = 8'($urandom);
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin_i = 1'($urandom);
    sub_i = 1'($urandom);
  endtask

  function automatic int pending(input bit w16);
    return w16 ? q16.size() : q8.size();
  endfunction

  // mode: 0 normal, 1 extra start mid-SHIFT, 2 reset mid-SHIFT
  task automatic run_op(input bit w16, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic s, input int mode);
    int   w;
    exp_t e;
    w = w16 ? 16 : 8;
    @(negedge clk);
    cin_i = c;
    sub_i = s;
    if (w16) begin a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1; end
    else     begin a8  = av[7:0];  b8  = bv[7:0];  start8  = 1'b1; end
    e = model(w, av, bv, c, s, cyc + 1 + w);
    if (mode != 2) begin
      if (w16) q16.push_back(e);
      else     q8.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    scramble();
    check(w16 ? "busy16_shift" : "busy8_shift", {31'd0, w16 ? busy16 : busy8}, 32'd1);
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      scramble();
      if (w16) start16 = 1'b1;
      else     start8  = 1'b1;
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      scramble();
      if (w16) rst16 = 1'b1;
      else     rst8  = 1'b1;
      @(negedge clk);
      rst8  = 1'b0;
      rst16 = 1'b0;
      check("busy_after_rst", {31'd0, w16 ? busy16 : busy8}, 32'd0);
      check("sum_after_rst", w16 ? {16'd0, sum16} : {24'd0, sum8}, 32'd0);
      repeat (w + 4) @(negedge clk);
    end
    for (int i = 0; i < 4 * w + 8; i++) begin
      if (pending(w16) == 0) break;
      @(negedge clk);
      scramble();
    end
    if (pending(w16) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: actual %0d results pending required 0", pending(w16));
      if (w16) q16.delete();
      else     q8.delete();
    end
    repeat (2) @(negedge clk);
    if (mode == 2) begin
      check("sum_hold_rst", w16 ? {16'd0, sum16} : {24'd0, sum8}, 32'd0);
    end else begin
      check("sum_hold", w16 ? {16'd0, sum16} : {24'd0, sum8}, e.sum);
      check("cout_hold", {31'd0, w16 ? cout16 : cout8}, {31'd0, e.cout});
    end
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
    check("rst_busy16", {31'd0, busy16}, 32'd0);
    check("rst_sum16", {16'd0, sum16}, 32'd0);
    rst8 = 1'b0; rst16 = 1'b0;

    run_op(0, 3,   5, 0, 0, 0);
    run_op(0, 255, 1, 0, 0, 0);
    run_op(0, 127, 1, 0, 0, 0);
    run_op(0, 5,   7, 0, 1, 0);
    run_op(0, 128, 1, 0, 1, 0);
    run_op(0, 5,   7, 1, 1, 0);
    run_op(0, 1,   2, 1, 0, 0);
    run_op(0, 8'h5A, 8'h33, 0, 0, 1);
    run_op(0, 200, 100, 0, 0, 2);
    run_op(0, 100, 27, 1, 0, 0);
    run_op(1, 16'hFFFF, 16'h0000, 1, 0, 0);
    run_op(1, 16'h8000, 16'h0001, 0, 1, 0);
    run_op(1, 16'h1234, 16'h4321, 0, 0, 1);
    run_op(1, 16'h7FFF, 16'h0001, 0, 0, 2);

    for (int i = 0; i < 30; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 10; i++)
      run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
